l1_inst_cache_2way: RTL and testbench
=====================================

L1_INST_CACHE_2WAY -- requirements
Module: l1_inst_cache_2way

Interface
REQ-001 NUM_SETS, 128, sets per way; power of two, >=2.
REQ-002 WORDS_PER_LINE, 4, 32-bit words per line; power of two, 2..16.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 program_counter_address  input  32  fetch address, word aligned.
REQ-006 flush_req  input  1  one-cycle pulse; invalidate all lines (fence.i).
REQ-007 instruction  output  32  fetched word; 0 when stall_cpu=1.
REQ-008 stall_cpu  output  1  1 = CPU must hold PC.
REQ-009 instruction_memory_address  output  32  word address to memory; 0 when no request.
REQ-010 instruction_memory_request  output  1  memory read request.
REQ-011 instruction_memory_read_data  input  32  memory read data.
REQ-012 instruction_memory_ready  input  1  read_data valid this cycle; consumes request.
REQ-013 hit_count  output  32  lookup-hit counter (see Configuration).
REQ-014 miss_count  output  32  miss counter (see Configuration).

Function
REQ-015 SHALL be 2-way set-associative; offset=log2(WORDS_PER_LINE)+2 bits, index=log2(NUM_SETS) bits, tag=remaining upper bits.
REQ-016 SHALL keep one valid bit and tag per way per set, and one LRU bit per set (names the way to evict next).
REQ-017 States SHALL be IDLE, FILL, UPDATE, FLUSH.
REQ-018 IDLE hit (either way valid, tag match): stall_cpu=0, instruction=selected word, combinationally same cycle; LRU bit set to the other way on the clock edge.
REQ-019 IDLE miss: stall_cpu=1, latch PC as miss address, zero word counter, go FILL; miss_count increments once per miss, not per stalled cycle.
REQ-020 FILL: request=1, address={miss line base, counter, 2'b00}; each cycle ready=1, store read_data into refill buffer slot counter, counter+1; after word WORDS_PER_LINE-1 accepted, go UPDATE.
REQ-021 FILL SHALL hold request and address stable while ready=0, with no timeout.
REQ-022 UPDATE: stall_cpu=1, write buffer, tag, valid=1 to victim way of latched index; LRU set to the non-victim way; next state IDLE (re-lookup hits).
REQ-023 Victim: way 0 if invalid, else way 1 if invalid, else way named by LRU.
REQ-024 Lookup SHALL use live PC in IDLE; FILL/UPDATE SHALL use only the latched miss address (PC changes ignored).
REQ-025 flush_req in IDLE: go FLUSH next cycle; stall_cpu=1 in the flush cycle and during FLUSH.
REQ-026 flush_req during FILL/UPDATE: record pending flush; complete fill, then go FLUSH instead of IDLE after UPDATE.
REQ-027 FLUSH: sweep counter 0..NUM_SETS-1, clear both valid bits and LRU of one set per cycle, stall_cpu=1; then IDLE; flush_req during FLUSH ignored.
REQ-028 Tag/data arrays SHALL not be reset; only valid/LRU are cleared, via FLUSH.

Reset
REQ-029 rst_n low: state=FLUSH, sweep counter=0, pending flush=0, miss address=0, counters=0; outputs stall_cpu=1, request=0, address=0, instruction=0.
REQ-030 Reset mid-FILL SHALL drop request immediately; partial line never written.
REQ-031 After rst_n release: NUM_SETS stall cycles of FLUSH, then IDLE with all lines invalid.

Configuration
REQ-032 Macro L1_ICACHE_PERF_CNT_EN defined: hit_count increments per IDLE-hit cycle with stall_cpu=0, miss_count per REQ-019; both wrap at 2^32, cleared only by reset.
REQ-033 L1_ICACHE_PERF_CNT_EN undefined: no counter registers; hit_count and miss_count tied to 0; all other behaviour identical.

Verification
REQ-034 Reset, PC=0x0000_0000, ready=1 constant -> 128 stall cycles, then 4 requests to 0x00,0x04,0x08,0x0C, UPDATE, hit; instruction=mem[0].
REQ-035 Fill 0x0000_0000 and 0x0000_0800 (same set, defaults) -> both subsequently hit; access 0x0000_1000 evicts LRU line (0x000 if 0x800 was used last).
REQ-036 Ready held low 5 cycles per word during fill -> address/request stable throughout; line content correct.
REQ-037 flush_req at second FILL word -> fill completes, UPDATE, then 128-cycle FLUSH; re-access same PC misses.
REQ-038 PC changed to 0x40 mid-fill of 0x10 -> line 0x10 filled; 0x40 then misses and fills.
REQ-039 With L1_ICACHE_PERF_CNT_EN: 1 miss then 3 hits -> miss_count=1, hit_count=3; without macro -> both 0.

Source files
------------

// File: rtl/l1_inst_cache_2way.sv
// Two-way set-associative L1 instruction cache with LRU replacement, line refill and fence.i flush sweep.
// Optional performance counters are enabled by defining L1_ICACHE_PERF_CNT_EN.
module l1_inst_cache_2way #(
  parameter int NUM_SETS       = 128,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] program_counter_address,
  input  logic        flush_req,
  output logic [31:0] instruction,
  output logic        stall_cpu,
  output logic [31:0] instruction_memory_address,
  output logic        instruction_memory_request,
  input  logic [31:0] instruction_memory_read_data,
  input  logic        instruction_memory_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 32 - OFF_W;

  typedef enum logic [1:0] {IDLE, FILL, UPDATE, FLUSH} state_t;

  state_t              state;
  logic [IDX_W-1:0]    sweep_cnt;
  logic [WORD_W-1:0]   word_cnt;
  logic                flush_pend;
  logic [LINE_W-1:0]   miss_line;

  logic [31:0]         refill_buf [WORDS_PER_LINE];
  logic [TAG_W-1:0]    tag_mem    [2][NUM_SETS];
  logic [31:0]         data_mem   [2][NUM_SETS][WORDS_PER_LINE];
  logic [1:0]          valid      [NUM_SETS];
  logic [NUM_SETS-1:0] lru;

  logic [IDX_W-1:0]  pc_idx, miss_idx;
  logic [TAG_W-1:0]  pc_tag, miss_tag;
  logic [WORD_W-1:0] pc_word;
  logic [1:0]        way_hit, miss_valid;
  logic              hit_way, victim, lookup_hit, miss_start;
  logic              unused_pc_bits;

  assign pc_word  = program_counter_address[2 +: WORD_W];
  assign pc_idx   = program_counter_address[OFF_W +: IDX_W];
  assign pc_tag   = program_counter_address[31 -: TAG_W];
  assign miss_idx = miss_line[IDX_W-1:0];
  assign miss_tag = miss_line[LINE_W-1 -: TAG_W];
  assign unused_pc_bits = ^program_counter_address[1:0];

  assign way_hit[0] = valid[pc_idx][0] && (tag_mem[0][pc_idx] == pc_tag);
  assign way_hit[1] = valid[pc_idx][1] && (tag_mem[1][pc_idx] == pc_tag);
  assign hit_way    = !way_hit[0];

  // A flush request in IDLE wins over the lookup: the CPU is stalled and nothing is counted.
  assign lookup_hit = (state == IDLE) && !flush_req && (|way_hit);
  assign miss_start = (state == IDLE) && !flush_req && !(|way_hit);

  assign miss_valid = valid[miss_idx];
  assign victim     = !miss_valid[0] ? 1'b0 : (!miss_valid[1] ? 1'b1 : lru[miss_idx]);

  assign stall_cpu   = !lookup_hit;
  assign instruction = lookup_hit ? data_mem[hit_way][pc_idx][pc_word] : 32'd0;
  assign instruction_memory_request = (state == FILL);
  assign instruction_memory_address = (state == FILL) ? {miss_line, word_cnt, 2'b00} : 32'd0;

  // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FLUSH;
      sweep_cnt  <= '0;
      word_cnt   <= '0;
      flush_pend <= 1'b0;
      miss_line  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state     <= FLUSH;
            sweep_cnt <= '0;
          end else if (miss_start) begin
            miss_line <= program_counter_address[31:OFF_W];
            word_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (flush_req) flush_pend <= 1'b1;
          if (instruction_memory_ready) begin
            word_cnt <= word_cnt + 1'b1;
            if (&word_cnt) state <= UPDATE;
          end
        end
        UPDATE: begin
          if (flush_pend || flush_req) begin
            state      <= FLUSH;
            sweep_cnt  <= '0;
            flush_pend <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (&sweep_cnt) state <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; valid/LRU are cleared by the FLUSH sweep that reset enters.
  always_ff @(posedge clk) begin
    if (state == FILL && instruction_memory_ready) refill_buf[word_cnt] <= instruction_memory_read_data;
    if (lookup_hit) lru[pc_idx] <= !hit_way;
    if (state == UPDATE) begin
      valid[miss_idx][victim]   <= 1'b1;
      tag_mem[victim][miss_idx] <= miss_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++) data_mem[victim][miss_idx][w] <= refill_buf[w];
      lru[miss_idx] <= !victim;
    end
    if (state == FLUSH) begin
      valid[sweep_cnt] <= 2'b00;
      lru[sweep_cnt]   <= 1'b0;
    end
  end

`ifdef L1_ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_l1_inst_cache_2way.sv
// Randomized self-checking bench for l1_inst_cache_2way against a set/way/LRU reference model.
module tb_l1_inst_cache_2way;
  localparam int NUM_SETS   = 128;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;
`ifdef L1_ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        flush_req;
  logic [31:0] instruction;
  logic        stall_cpu;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  bit last_cached = 1'b0;
  logic [31:0] last_pc = 32'd0;

  // Reference cache: per set, per way valid/tag, plus the way to evict next.
  bit          m_valid [NUM_SETS][2];
  logic [31:0] m_tag   [NUM_SETS][2];
  int          m_lru   [NUM_SETS];

  always #5 clk = ~clk;

  l1_inst_cache_2way #(.NUM_SETS(NUM_SETS), .WORDS_PER_LINE(WPL)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .program_counter_address      (pc_in),
    .flush_req                    (flush_req),
    .instruction                  (instruction),
    .stall_cpu                    (stall_cpu),
    .instruction_memory_address   (mem_addr),
    .instruction_memory_request   (mem_req),
    .instruction_memory_read_data (mem_rdata),
    .instruction_memory_ready     (mem_ready),
    .hit_count                    (hit_count),
    .miss_count                   (miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % NUM_SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (LINE_BYTES * NUM_SETS);
  endfunction

  function automatic int m_lookup(input logic [31:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return w;
    return -1;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s] = 0;
    end
  endtask

  task automatic m_install(input logic [31:0] a);
    int s, v;
    s = set_of(a);
    v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = tag_of(a);
    m_lru[s]      = 1 - v;
  endtask

  task automatic check_counters();
    check("hit_count",  hit_count,  PERF ? 32'(exp_hits)   : 32'd0);
    check("miss_count", miss_count, PERF ? 32'(exp_misses) : 32'd0);
  endtask

  // Assumes the next falling edge lands in the first FLUSH cycle.
  task automatic wait_flush();
    for (int i = 0; i < NUM_SETS; i++) begin
      @(negedge clk);
      flush_req = (i == 3);
      mem_ready = 1'b0;
      #1;
      check("flush_stall", 32'(stall_cpu), 32'd1);
      check("flush_req_out", 32'(mem_req), 32'd0);
    end
    flush_req = 1'b0;
    m_clear();
  endtask

  // One IDLE lookup; on a miss, serve the whole refill and the UPDATE cycle.
  task automatic fetch(input logic [31:0] pc, input int dly, input int flush_at, input logic [31:0] pc_mid);
    int way, d;
    bit pend;
    logic [31:0] base, exp_addr;
    @(negedge clk);
    pc_in = pc; flush_req = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
    #1;
    check_counters();
    way = m_lookup(pc);
    if (way >= 0) begin
      check("hit_stall", 32'(stall_cpu), 32'd0);
      check("hit_instr", instruction, mem_word(pc));
      check("hit_req", 32'(mem_req), 32'd0);
      m_lru[set_of(pc)] = 1 - way;
      exp_hits++;
      last_pc = pc; last_cached = 1'b1;
      return;
    end
    check("miss_stall", 32'(stall_cpu), 32'd1);
    check("miss_instr", instruction, 32'd0);
    exp_misses++;
    pend = 1'b0;
    base = pc & ~32'(LINE_BYTES - 1);
    for (int w = 0; w < WPL; w++) begin
      d = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
      exp_addr = base + 32'(w * 4);
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        pc_in = pc_mid;
        mem_ready = (k == d);
        mem_rdata = mem_ready ? mem_word(exp_addr) : $urandom;
        flush_req = (w == flush_at) && (k == 0);
        if (flush_req) pend = 1'b1;
        #1;
        check("fill_req", 32'(mem_req), 32'd1);
        check("fill_addr", mem_addr, exp_addr);
        check("fill_stall", 32'(stall_cpu), 32'd1);
        check("fill_instr", instruction, 32'd0);
      end
    end
    @(negedge clk);
    mem_ready = 1'b0; flush_req = 1'b0;
    #1;
    check("upd_stall", 32'(stall_cpu), 32'd1);
    check("upd_req", 32'(mem_req), 32'd0);
    check("upd_addr", mem_addr, 32'd0);
    m_install(pc);
    last_pc = pc; last_cached = !pend;
    if (pend) wait_flush();
  endtask

  task automatic do_flush(input logic [31:0] pc);
    @(negedge clk);
    pc_in = pc; flush_req = 1'b1; mem_ready = 1'b0;
    #1;
    check_counters();
    check("idle_flush_stall", 32'(stall_cpu), 32'd1);
    check("idle_flush_instr", instruction, 32'd0);
    last_cached = 1'b0;
    wait_flush();
  endtask

  initial begin
    logic [31:0] pc, pc2;
    int r;
    rst_n = 1'b0; pc_in = 32'd0; flush_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'd0;
    m_clear();
    #3;
    check("rst_stall", 32'(stall_cpu), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check_counters();
    @(posedge clk); #2 rst_n = 1'b1;
    wait_flush();

    // Cold miss at PC 0 with ready always high, then hit.
    fetch(32'h0000_0000, 0, -1, 32'h0000_0000);
    fetch(32'h0000_0000, 0, -1, 32'h0000_0000);
    // Two tags in set 0, then a third evicts the least recently used one.
    fetch(32'h0000_0800, 0, -1, 32'h0000_0800);
    fetch(32'h0000_0804, 0, -1, 32'h0000_0804);
    fetch(32'h0000_0008, 0, -1, 32'h0000_0008);
    fetch(32'h0000_080C, 0, -1, 32'h0000_080C);
    fetch(32'h0000_1000, 0, -1, 32'h0000_1000);
    fetch(32'h0000_0800, 0, -1, 32'h0000_0800);
    fetch(32'h0000_0000, 0, -1, 32'h0000_0000);
    // Slow memory: five wait cycles per word.
    fetch(32'h0000_2230, 5, -1, 32'h0000_2230);
    fetch(32'h0000_2234, 0, -1, 32'h0000_2234);
    // Flush arriving on the second fill word, then re-access misses.
    fetch(32'h0000_0120, 0, 1, 32'h0000_0120);
    fetch(32'h0000_0120, 0, -1, 32'h0000_0120);
    // PC moves to 0x40 while 0x10 fills.
    fetch(32'h0000_0010, 1, -1, 32'h0000_0040);
    fetch(32'h0000_0040, 0, -1, 32'h0000_0040);
    fetch(32'h0000_0014, 0, -1, 32'h0000_0014);

    // Reset in the middle of a refill drops the request at once.
    @(negedge clk);
    pc_in = 32'h0000_7000; flush_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("rmf_stall", 32'(stall_cpu), 32'(m_lookup(32'h0000_7000) < 0));
    @(negedge clk); #1;
    check("rmf_req", 32'(mem_req), 32'd1);
    @(negedge clk); mem_ready = 1'b1; mem_rdata = mem_word(32'h0000_7000);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rmf_req_drop", 32'(mem_req), 32'd0);
    check("rmf_addr", mem_addr, 32'd0);
    check("rmf_rst_stall", 32'(stall_cpu), 32'd1);
    exp_hits = 0; exp_misses = 0;
    check_counters();
    @(posedge clk); #2 rst_n = 1'b1; mem_ready = 1'b0;
    wait_flush();

    // One miss then three hits.
    fetch(32'h0000_7000, 0, -1, 32'h0000_7000);
    fetch(32'h0000_7000, 0, -1, 32'h0000_7000);
    fetch(32'h0000_7004, 0, -1, 32'h0000_7004);
    fetch(32'h0000_7008, 0, -1, 32'h0000_7008);
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    check("perf_miss", miss_count, PERF ? 32'd1 : 32'd0);
    check("perf_hit", hit_count, PERF ? 32'd3 : 32'd0);
    wait_flush();

    // Random traffic over four tags and four sets so evictions are frequent.
    for (int i = 0; i < 200; i++) begin
      pc = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, WPL - 1)) << 2);
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        fetch(pc, -1, int'($urandom_range(0, WPL - 1)), pc);
      end else if (r == 1 && last_cached) begin
        do_flush(last_pc);
      end else if (r == 2) begin
        pc2 = $urandom & 32'hFFFF_FFFC;
        fetch(pc, -1, -1, pc2);
      end else begin
        fetch(pc, -1, -1, pc);
      end
    end
    fetch(last_pc, 0, -1, last_pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
